// File: rtl/pipe_pkg.sv
// Shared constants and FSM state type for the pipeline hazard/redirect controller.
package pipe_pkg;

  localparam logic [3:0]  STALL_NONE    = 4'b0000;
  localparam logic [3:0]  STALL_LOADUSE = 4'b0011;
  localparam logic [3:0]  STALL_DIV     = 4'b0111;
  localparam logic [31:0] BOOT_PC       = 32'h0000_3000;

  typedef enum logic [1:0] {
    StIdle,
    StDivBusy,
    StFlush
  } pipe_state_e;

endpackage

// File: rtl/pipe_div_timer.sv
// Multi-cycle divide down-counter; raises a one-cycle div_done after the count expires.
module pipe_div_timer
  import pipe_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  input  logic abort,
  output logic expire,
  output logic div_done
);

  localparam int unsigned CntW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;

  // Start cycle already counts as a stall cycle, hence the -2 preload.
  always_comb begin
    cnt_d = cnt_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = CntW'(DIV_CYCLES - 2);
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  assign expire = run && (cnt_q == '0);
  assign done_d = expire && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign div_done = done_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use and divide stalls, exception/eret redirect.
// Optional stall statistics counter enabled by defining PIPE_CTRL_STALL_CNT_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_3180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_id,
  input  logic        div_start,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [3:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        div_done,
  output logic        busy,
  output logic [31:0] stall_cycles
);

  pipe_state_e state_q, state_d;
  logic [31:0] new_pc_q;
  logic        redirect;
  logic        div_go;
  logic        expire;

  assign redirect = exc_req || eret_req;
  // A redirect in the same cycle swallows the divide request.
  assign div_go   = (state_q == StIdle) && div_start && !redirect;

  pipe_div_timer #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_go),
    .run      (state_q == StDivBusy),
    .abort    (redirect),
    .expire   (expire),
    .div_done (div_done)
  );

  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = StFlush;
    end else begin
      case (state_q)
        StIdle:    if (div_start) state_d = StDivBusy;
        StDivBusy: if (expire) state_d = StIdle;
        StFlush:   state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    stall = STALL_NONE;
    if (state_q != StFlush) begin
      if (stallreq_id)                          stall = stall | STALL_LOADUSE;
      if (state_q == StDivBusy)                 stall = stall | STALL_DIV;
      if ((state_q == StIdle) && div_start)     stall = stall | STALL_DIV;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      new_pc_q <= BOOT_PC;
    end else begin
      state_q <= state_d;
      if (exc_req) begin
        new_pc_q <= EXC_VECTOR;
      end else if (eret_req) begin
        new_pc_q <= epc;
      end
    end
  end

  assign flush  = (state_q == StFlush);
  assign busy   = (state_q == StDivBusy);
  assign new_pc = new_pc_q;

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if ((stall != STALL_NONE) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_CYCLES, default 32, giving the total stall cycles per divide (legal range 2..64).
REQ-002 The block SHALL have parameter EXC_VECTOR, default 32'h0000_3180, giving the exception redirect address.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 stallreq_id  in  1  load-use hazard request from ID, level.
REQ-006 div_start  in  1  EX starts a multi-cycle divide, 1-cycle pulse.
REQ-007 exc_req  in  1  MEM-stage exception, 1-cycle pulse.
REQ-008 eret_req  in  1  MEM-stage exception-return, 1-cycle pulse.
REQ-009 epc  in  32  return address for eret_req.
REQ-010 stall  out  4  hold vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM.
REQ-011 flush  out  1  pipeline flush, 1-cycle pulse.
REQ-012 new_pc  out  32  redirect target, valid while flush=1.
REQ-013 div_done  out  1  divide-complete pulse.
REQ-014 busy  out  1  high while in DIV_BUSY.
REQ-015 stall_cycles  out  32  stall statistics counter (see Configuration).

Function
REQ-016 Stage k SHALL hold when stall[k]=1; stage k+1 SHALL receive a bubble when stall[k]=1 and stall[k+1]=0.
REQ-017 FSM states SHALL be IDLE, DIV_BUSY, FLUSH.
REQ-018 stall SHALL be combinational: 4'b0000 in FLUSH; otherwise the OR of 4'b0011 when stallreq_id=1, 4'b0111 when in DIV_BUSY, and 4'b0111 when div_start=1 in IDLE.
REQ-019 div_start sampled in IDLE SHALL enter DIV_BUSY, with the down-counter loaded to DIV_CYCLES-2 (width $clog2(DIV_CYCLES)).
REQ-020 In DIV_BUSY the counter SHALL decrement each cycle; when it reaches 0, the next cycle SHALL be IDLE with div_done=1 for exactly one cycle.
REQ-021 Result: stall=4'b0111 for exactly DIV_CYCLES cycles, starting in the div_start cycle, and div_done=1 in the first cycle after the stall.
REQ-022 div_start SHALL be ignored in DIV_BUSY and FLUSH.
REQ-023 exc_req or eret_req sampled in any state SHALL enter FLUSH for exactly one cycle, with flush=1 registered, and abort any divide without raising div_done.
REQ-024 In FLUSH, new_pc SHALL be EXC_VECTOR for exc_req, or the epc value sampled with eret_req.
REQ-025 If exc_req and eret_req are both high, exc_req SHALL win.
REQ-026 exc_req or eret_req sampled during FLUSH SHALL produce a back-to-back flush in the next cycle; otherwise the state SHALL go FLUSH->IDLE.
REQ-027 Exception or eret priority SHALL exceed div_start in the same cycle; that div_start SHALL be dropped.
REQ-028 busy SHALL equal (state==DIV_BUSY).
REQ-029 new_pc SHALL hold its last value outside FLUSH.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE, counter=0, flush=0, div_done=0, new_pc=32'h0000_3000, stall_cycles=0; stall then follows REQ-018 from the inputs.
REQ-031 Reset mid-divide SHALL abandon the divide with no div_done.

Configuration
REQ-032 With PIPE_CTRL_STALL_CNT_EN defined, stall_cycles SHALL increment by 1 on each clk edge where stall!=0, saturating at 32'hFFFF_FFFF.
REQ-033 Without PIPE_CTRL_STALL_CNT_EN, stall_cycles SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-034 A shared package pipe_pkg SHALL hold: stall constants STALL_NONE=4'b0000, STALL_LOADUSE=4'b0011, STALL_DIV=4'b0111; BOOT_PC=32'h0000_3000; the FSM state typedef.
REQ-035 The divide down-counter and div_done generation SHALL be one sub-module, pipe_div_timer.

Verification
REQ-036 Reset release, idle inputs -> stall=0, flush=0, new_pc=32'h0000_3000, busy=0.
REQ-037 div_start pulse at cycle t, DIV_CYCLES=32 -> stall=4'b0111 for cycles t..t+31, div_done=1 only at t+32, busy=1 for t+1..t+31.
REQ-038 stallreq_id=1 alone for 3 cycles -> stall=4'b0011 for those 3 cycles; stallreq_id=1 during DIV_BUSY -> stall=4'b0111.
REQ-039 exc_req at cycle t+5 of a divide -> flush=1, new_pc=32'h0000_3180, stall=0 at t+6; no div_done; IDLE at t+7.
REQ-040 exc_req and eret_req together (epc=32'h0000_3044), then eret_req alone next cycle -> flush=1 in two consecutive cycles, new_pc=32'h0000_3180 then 32'h0000_3044.
REQ-041 rst_n=0 asserted mid-divide, asynchronously -> immediately busy=0 and flush=0; with PIPE_CTRL_STALL_CNT_EN, stall_cycles=0.
